// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-clock divider plus horizontal/vertical raster counters for a VGA
//   style display, with a registered output stage that adds one pixel of
//   latency. That stage carries the syncs, the blanking and the colour
//   composited from one sprite layer over a flat background.
// Ports
//   clk, rst_n                : system clock, asynchronous active-low reset
//   spr_R/G/B, spr_visible    : sprite colour / opacity for current x_pos,y_pos
//   x_pos, y_pos              : raw h/v counters (valid in blanking too)
//   pix_en                    : one-clk strobe, one per pixel
//   hsync_n, vsync_n, blank_n : registered, active-low syncs / active video
//   vga_R/G/B                 : registered pixel colour
//   frame_start               : one-clk pulse when the raster returns to (0,0)
module vga_timing_gen #(
  parameter int        H_ACTIVE = 640,
  parameter int        H_FP     = 16,
  parameter int        H_SYNC   = 96,
  parameter int        H_BP     = 48,
  parameter int        V_ACTIVE = 480,
  parameter int        V_FP     = 10,
  parameter int        V_SYNC   = 2,
  parameter int        V_BP     = 33,
  parameter int        CLK_DIV  = 2,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] spr_R,
  input  logic [7:0] spr_G,
  input  logic [7:0] spr_B,
  input  logic       spr_visible,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       pix_en,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic [7:0] vga_R,
  output logic [7:0] vga_G,
  output logic [7:0] vga_B,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All boundaries pre-sized to the 10-bit counter width; sync ends are
  // exclusive so no comparison needs a wider operand.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0] div_q, div_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_n_q, vsync_n_q, blank_n_q, frame_start_q;
  logic [7:0] r_q, g_q, b_q;

  logic       pix_tick, h_wrap, v_wrap, active, in_hs, in_vs;
  logic [7:0] r_d, g_d, b_d;

  assign pix_tick = (div_q == DIV_LAST);
  assign h_wrap   = (h_cnt_q == H_LAST);
  assign v_wrap   = (v_cnt_q == V_LAST);
  assign active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign in_hs    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign in_vs    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

  always_comb begin
    div_d   = pix_tick ? '0 : div_q + 2'd1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      r_d = spr_visible ? spr_R : BG_COLOR;
      g_d = spr_visible ? spr_G : BG_COLOR;
      b_d = spr_visible ? spr_B : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= pix_tick && h_wrap && v_wrap;
      if (pix_tick) begin
        hsync_n_q <= !in_hs;
        vsync_n_q <= !in_vs;
        blank_n_q <= active;
        r_q       <= r_d;
        g_q       <= g_d;
        b_q       <= b_d;
      end
    end
  end

  // Gated by rst_n so the strobe is low during reset even when CLK_DIV=1
  // keeps the divider permanently at its terminal value.
  assign pix_en      = rst_n && pix_tick;
  assign x_pos       = h_cnt_q;
  assign y_pos       = v_cnt_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign blank_n     = blank_n_q;
  assign vga_R       = r_q;
  assign vga_G       = g_q;
  assign vga_B       = b_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: default geometry, CLK_DIV=2, background 00
  // Instance 1: tiny geometry 25x15, CLK_DIV=2, background 5A
  // Instance 2: default geometry, CLK_DIV=1, background 21
  logic [7:0] s0R = 8'h00, s0G = 8'h00, s0B = 8'h00;
  logic       s0V = 1'b0;
  logic [7:0] s1R, s1G, s1B, s2R, s2G, s2B;
  logic       s1V, s2V;

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic       pe0, hs0, vs0, bl0, fs0;
  logic       pe1, hs1, vs1, bl1, fs1;
  logic       pe2, hs2, vs2, bl2, fs2;
  logic [7:0] R0, G0, B0, R1, G1, B1, R2, G2, B2;

  vga_timing_gen #(.CLK_DIV(2)) u_def (
    .clk(clk), .rst_n(rst_n), .spr_R(s0R), .spr_G(s0G), .spr_B(s0B), .spr_visible(s0V),
    .x_pos(x0), .y_pos(y0), .pix_en(pe0), .hsync_n(hs0), .vsync_n(vs0), .blank_n(bl0),
    .vga_R(R0), .vga_G(G0), .vga_B(B0), .frame_start(fs0));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                   .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
                   .CLK_DIV(2), .BG_COLOR(8'h5A)) u_small (
    .clk(clk), .rst_n(rst_n), .spr_R(s1R), .spr_G(s1G), .spr_B(s1B), .spr_visible(s1V),
    .x_pos(x1), .y_pos(y1), .pix_en(pe1), .hsync_n(hs1), .vsync_n(vs1), .blank_n(bl1),
    .vga_R(R1), .vga_G(G1), .vga_B(B1), .frame_start(fs1));

  vga_timing_gen #(.CLK_DIV(1), .BG_COLOR(8'h21)) u_div1 (
    .clk(clk), .rst_n(rst_n), .spr_R(s2R), .spr_G(s2G), .spr_B(s2B), .spr_visible(s2V),
    .x_pos(x2), .y_pos(y2), .pix_en(pe2), .hsync_n(hs2), .vsync_n(vs2), .blank_n(bl2),
    .vga_R(R2), .vga_G(G2), .vga_B(B2), .frame_start(fs2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k = clock edges since reset release; pixel index = k / CLK_DIV.
  int unsigned k0, k1, k2;
  logic [23:0] c0, c1, c2;

  function automatic logic [23:0] pix_col(input int HA, input int HT, input int VA, input int VT,
                                          input int unsigned pix, input logic vis,
                                          input logic [23:0] rgb, input logic [7:0] bg);
    int unsigned p, x, y;
    p = pix % (HT * VT);
    x = p % HT;
    y = p / HT;
    if (x < HA && y < VA) return vis ? rgb : {bg, bg, bg};
    return 24'h0;
  endfunction

  function automatic logic [48:0] exp_out(input int HA, input int HF, input int HS, input int HB,
                                          input int VA, input int VF, input int VS, input int VB,
                                          input int D, input int unsigned kk, input logic in_rst,
                                          input logic [23:0] col);
    int unsigned ht, vt, tot, pix, p, q, x, y, qx, qy;
    logic pe, hs, vs, bl, fs;
    if (in_rst) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
    ht  = HA + HF + HS + HB;
    vt  = VA + VF + VS + VB;
    tot = ht * vt;
    pix = kk / D;
    p   = pix % tot;
    x   = p % ht;
    y   = p / ht;
    pe  = (kk % D) == D - 1;
    if (pix == 0) begin
      hs = 1'b1; vs = 1'b1; bl = 1'b0; fs = 1'b0;
    end else begin
      q  = (pix - 1) % tot;
      qx = q % ht;
      qy = q / ht;
      hs = !(qx >= HA + HF && qx < HA + HF + HS);
      vs = !(qy >= VA + VF && qy < VA + VF + VS);
      bl = (qx < HA) && (qy < VA);
      fs = ((kk % D) == 0) && (p == 0);
    end
    return {10'(x), 10'(y), pe, hs, vs, bl, fs, col};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k0 <= 0; k1 <= 0; k2 <= 0;
      c0 <= '0; c1 <= '0; c2 <= '0;
    end else begin
      k0 <= k0 + 1;
      k1 <= k1 + 1;
      k2 <= k2 + 1;
      if (k0 % 2 == 1) c0 <= pix_col(640, 800, 480, 525, k0 / 2, s0V, {s0R, s0G, s0B}, 8'h00);
      if (k1 % 2 == 1) c1 <= pix_col(16, 25, 8, 15, k1 / 2, s1V, {s1R, s1G, s1B}, 8'h5A);
      c2 <= pix_col(640, 800, 480, 525, k2, s2V, {s2R, s2G, s2B}, 8'h21);
    end
  end

  // Sprite patterns for instances 1 and 2 follow the model's own raster position.
  always_comb begin
    int unsigned p;
    p   = (k1 / 2) % 375;
    s1V = ((p % 25) + (p / 25)) % 3 != 0;
    s1R = 8'(p);
    s1G = 8'(p * 3);
    s1B = 8'(~p);
    s2V = k2[2];
    s2R = 8'(k2);
    s2G = 8'(k2 >> 3);
    s2B = 8'hC3;
  end

  always @(negedge clk) begin
    chk("dut0 outputs", {x0, y0, pe0, hs0, vs0, bl0, fs0, R0, G0, B0},
        exp_out(640, 16, 96, 48, 480, 10, 2, 33, 2, k0, !rst_n, c0));
    chk("dut1 outputs", {x1, y1, pe1, hs1, vs1, bl1, fs1, R1, G1, B1},
        exp_out(16, 2, 4, 3, 8, 2, 2, 3, 2, k1, !rst_n, c1));
    chk("dut2 outputs", {x2, y2, pe2, hs2, vs2, bl2, fs2, R2, G2, B2},
        exp_out(640, 16, 96, 48, 480, 10, 2, 33, 1, k2, !rst_n, c2));
  end

  int unsigned pe0cnt = 0;
  int unsigned low2 = 0;
  always @(negedge clk) begin
    if (pe0) pe0cnt <= pe0cnt + 1;
    if (rst_n && !pe2) low2 <= low2 + 1;
  end

  // ---------------- directed helpers ----------------
  function automatic logic getsig(input int w);
    case (w)
      0:       return hs0;
      1:       return hs2;
      2:       return fs1;
      default: return hs1;
    endcase
  endfunction

  task automatic wait_edge(input int w, input logic from, input int budget, output int unsigned t);
    logic prev, cur;
    bit found;
    found = 0;
    t = 0;
    prev = getsig(w);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      cur = getsig(w);
      if (prev == from && cur != from) begin
        found = 1;
        t = cyc;
        break;
      end
      prev = cur;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL edge wait sig%0d: got no edge, expected one within %0d clks", w, budget);
    end
  endtask

  task automatic wait_x0(input int unsigned xv, input int budget);
    bit found;
    found = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (x0 == 10'(xv) && pe0 && y0 < 10'd480) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL x_pos wait: got no x_pos=%0d, expected within %0d clks", xv, budget);
    end
  endtask

  task automatic first_pe_after_release();
    int unsigned n;
    n = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (pe0) begin
        n = i;
        break;
      end
    end
    chk("first pix_en edge count", 64'(n), 64'd1);
    chk("x_pos at first pix_en", 64'(x0), 64'd0);
    chk("y_pos at first pix_en", 64'(y0), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned t1, t2, tr, p1, vlow, hf, prevh;
    bit found;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset hsync_n", 64'(hs0), 64'd1);
    chk("reset blank_n", 64'(bl0), 64'd0);
    chk("reset pix_en div1", 64'(pe2), 64'd0);
    #2 rst_n = 1'b1;
    #1 chk("div1 pix_en after release", 64'(pe2), 64'd1);
    first_pe_after_release();

    // Frame timing and wrap on the small raster (25 px x 15 lines, 2 clk/px).
    wait_edge(2, 1'b0, 2000, t1);
    vlow = 0; hf = 0; found = 0; t2 = 0;
    prevh = 32'(hs1);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!vs1 && pe1) vlow++;
      if (prevh == 1 && !hs1) hf++;
      prevh = 32'(hs1);
      if (fs1) begin
        found = 1;
        t2 = cyc;
        break;
      end
    end
    chk("small frame_start found", 64'(found), 64'd1);
    chk("small frame_start period", 64'(t2 - t1), 64'd750);
    chk("small vsync low pixels", 64'(vlow), 64'd50);
    chk("small lines per frame", 64'(hf), 64'd15);

    found = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (x1 == 10'd24 && y1 == 10'd14 && pe1) begin
        found = 1;
        break;
      end
    end
    chk("wrap corner reached", 64'(found), 64'd1);
    @(negedge clk);
    chk("wrap x_pos", 64'(x1), 64'd0);
    chk("wrap y_pos", 64'(y1), 64'd0);
    chk("wrap frame_start", 64'(fs1), 64'd1);
    @(negedge clk);
    chk("frame_start one clk", 64'(fs1), 64'd0);

    found = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (x1 == 10'd24 && y1 == 10'd7 && pe1) begin
        found = 1;
        break;
      end
    end
    chk("last active line end reached", 64'(found), 64'd1);
    @(negedge clk);
    chk("line after active y_pos", 64'(y1), 64'd8);
    chk("line after active blank_n", 64'(bl1), 64'd0);

    // Line timing, default geometry.
    wait_edge(0, 1'b1, 4000, t1);
    p1 = pe0cnt;
    chk("hsync fall x_pos", 64'(x0), 64'd657);
    wait_edge(0, 1'b0, 4000, tr);
    chk("hsync low clks", 64'(tr - t1), 64'd192);
    wait_edge(0, 1'b1, 4000, t2);
    chk("hsync fall period", 64'(t2 - t1), 64'd1600);
    chk("pixels per line", 64'(pe0cnt - p1), 64'd800);

    // Compositing.
    wait_x0(320, 4000);
    s0V = 1'b1; s0R = 8'hFF; s0G = 8'h11; s0B = 8'h22;
    @(negedge clk);
    chk("sprite vga_R", 64'(R0), 64'hFF);
    chk("sprite vga_G", 64'(G0), 64'h11);
    chk("sprite x_pos one pixel on", 64'(x0), 64'd321);
    wait_x0(330, 100);
    s0V = 1'b0;
    @(negedge clk);
    chk("background vga_R", 64'(R0), 64'h00);
    wait_x0(700, 1000);
    s0V = 1'b1;
    @(negedge clk);
    chk("blanking vga_R", 64'(R0), 64'h00);
    s0V = 1'b0;

    // CLK_DIV=1 line period.
    wait_edge(1, 1'b1, 2000, t1);
    wait_edge(1, 1'b1, 2000, t2);
    chk("div1 hsync period", 64'(t2 - t1), 64'd800);
    chk("div1 pix_en low count", 64'(low2), 64'd0);

    // Reset in the middle of an hsync pulse.
    wait_edge(0, 1'b1, 4000, t1);
    repeat (5) @(negedge clk);
    chk("in hsync before reset", 64'(hs0), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset hsync_n", 64'(hs0), 64'd1);
    chk("mid reset blank_n", 64'(bl0), 64'd0);
    chk("mid reset x_pos", 64'(x0), 64'd0);
    chk("mid reset pix_en", 64'(pe0), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    first_pe_after_release();
    repeat (2000) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (1..4)
- BG_COLOR, 8'h00, background level driven on R/G/B when no sprite is visible
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- spr_R / spr_G / spr_B, in, 8 each, sprite colour for the current x_pos/y_pos
- spr_visible, in, 1, sprite pixel opaque
- x_pos, out, 10, horizontal counter h_cnt (0..H_TOTAL-1)
- y_pos, out, 10, vertical counter v_cnt (0..V_TOTAL-1)
- pix_en, out, 1, one-clk pixel strobe
- hsync_n / vsync_n, out, 1 each, active-low syncs
- blank_n, out, 1, high during active video
- vga_R / vga_G / vga_B, out, 8 each, pixel colour
- frame_start, out, 1, one-clk pulse at frame origin
REQ-003 The block SHALL use the single clock clk; rst_n SHALL be asynchronous and active-low.

Function
REQ-004 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-005 A divider counter SHALL count 0..CLK_DIV-1 and wrap; pix_en SHALL be high exactly when the divider equals CLK_DIV-1; with CLK_DIV=1, pix_en SHALL be constantly high out of reset.
REQ-006 h_cnt SHALL increment on each clk edge with pix_en=1 and wrap from H_TOTAL-1 to 0.
REQ-007 v_cnt SHALL increment only on the edge where h_cnt wraps, and wrap from V_TOTAL-1 to 0 on that same edge.
REQ-008 x_pos/y_pos SHALL equal h_cnt/v_cnt at all times, including blanking; sprites perform their own bounds check.
REQ-009 active SHALL be defined as (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-010 The output stage SHALL be registered on pix_en, giving one pixel of latency after x_pos/y_pos.
- blank_n <= active
- hsync_n <= !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1])
- vsync_n <= !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1])
REQ-011 vga_R/G/B SHALL be registered as follows:
- active && spr_visible: spr_R/G/B
- active && !spr_visible: BG_COLOR
- !active: 8'h00, regardless of spr_* inputs
REQ-012 Sync, blank and colour outputs SHALL hold their values between pix_en strobes.
REQ-013 frame_start SHALL pulse high for exactly one clk on the edge after which h_cnt=0 and v_cnt=0, and SHALL remain low otherwise.
REQ-014 Counter widths SHALL be 10 bits, and no intermediate comparison SHALL overflow for the default parameters.

Reset
REQ-015 While rst_n=0, outputs SHALL immediately take these values:
- divider, h_cnt, v_cnt: 0
- x_pos, y_pos: 0
- pix_en, frame_start: 0
- hsync_n, vsync_n: 1
- blank_n: 0
- vga_R/G/B: 0
REQ-016 After rst_n rises, the first pix_en SHALL occur on clk cycle CLK_DIV-1 counted from release, and timing SHALL restart from pixel (0,0).
REQ-017 Asserting reset mid-frame SHALL abort the frame, with no partial sync pulse held low after reset asserts.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Line timing: run with default parameters -> hsync_n falling edges 1600 clks apart; hsync_n low for 192 clks; first fall one pixel after x_pos=656.
- Frame timing: run 2 frames -> vsync_n low for 1600 pix_en (2 lines); frame_start period 840000 clks; 800 pixels per line; 525 lines per frame.
- Wrap: at x_pos=799, y_pos=524 with pix_en=1 -> next x_pos=0 and y_pos=0; frame_start=1 for one clk; x_pos=799 at y_pos=479 -> y_pos=480 with blank_n=0 from the next pixel.
- Compositing: spr_visible=1 with spr_R=8'hFF at x_pos=320,y_pos=240 -> vga_R=8'hFF one pixel later; spr_visible=0 -> vga_R=BG_COLOR; spr_visible=1 at x_pos=700 -> vga_R=8'h00.
- Reset mid-sync: drop rst_n while hsync_n=0 -> hsync_n=1, blank_n=0, x_pos=0 immediately; after release the first pix_en follows REQ-016.
- CLK_DIV=1: pix_en constantly high; line period = 800 clks.
